// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM state type, frame-format limits and parity encodings shared by
// the configurable UART receiver files.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int PRESCALE_MIN = 4;
   localparam int DATA_LEN_MIN = 5;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: per-bit edge counter, 3-tap majority vote around mid-bit and
// a one-cycle decision strobe once the voted value is stable.
module uart_rx_bit_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_s,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  bit_val,
   output logic                  decide
);

   localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] half;
   logic [2:0]            taps;

   assign half = prescale >> 1;

   // The strobe is registered off the last tap, so it lands on edge P/2+2 even when
   // that position wraps into the next bit (P = 4).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt <= '0;
         taps     <= '0;
         decide   <= 1'b0;
      end else if (clear) begin
         edge_cnt <= '0;
         decide   <= 1'b0;
      end else begin
         edge_cnt <= (edge_cnt == prescale - ONE) ? '0 : edge_cnt + ONE;
         if (edge_cnt == half - ONE || edge_cnt == half || edge_cnt == half + ONE)
            taps <= {taps[1:0], rx_s};
         decide <= (edge_cnt == half + ONE);
      end
   end

   assign bit_val = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with run-time frame format (length, parity, stop bits, prescale).
// Define UART_RX_BREAK_DET_EN to add the brk_det output for all-zero (break) frames.
module uart_rx_cfg
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH_MAX = 8,
   parameter int PRESCALE_W     = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [3:0]                DATA_LEN,
   input  logic                      STOP2,
   input  logic [PRESCALE_W-1:0]     Prescale,
   output logic [DATA_WIDTH_MAX-1:0] P_DATA,
   output logic                      data_valid,
   output logic                      par_error,
   output logic                      stp_error,
   output logic                      strt_glitch,
`ifdef UART_RX_BREAK_DET_EN
   output logic                      brk_det,
`endif
   output logic                      busy
);

   localparam logic [3:0]            LEN_MIN = 4'(DATA_LEN_MIN);
   localparam logic [3:0]            LEN_MAX = 4'(DATA_WIDTH_MAX);
   localparam logic [PRESCALE_W-1:0] PSC_MIN = PRESCALE_W'(PRESCALE_MIN);

   state_t                    state, next_state;
   logic                      rx_meta, rx_s, rx_prev;
   logic                      par_en_q, par_typ_q, stop2_q;
   logic [3:0]                len_q;
   logic [PRESCALE_W-1:0]     psc_q;
   logic [DATA_WIDTH_MAX-1:0] shreg;
   logic [3:0]                bit_cnt;
   logic                      stop_cnt, par_err_q, stp_err_q;
   logic                      bit_val, decide, start_det, glitch, frame_done;
   logic                      exp_par, stp_err_final;
`ifdef UART_RX_BREAK_DET_EN
   logic                      all_zero;
`endif

   uart_rx_bit_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
      .clk      (CLK),
      .rst      (RST),
      .rx_s     (rx_s),
      .clear    (start_det),
      .prescale (psc_q),
      .bit_val  (bit_val),
      .decide   (decide)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first so no path infers a latch.
      next_state = state;
      start_det  = 1'b0;
      glitch     = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE:   if (rx_prev && !rx_s) begin
                    start_det  = 1'b1;
                    next_state = START;
                 end
         START:  if (decide) begin
                    if (bit_val) begin
                       glitch     = 1'b1;
                       next_state = IDLE;
                    end else begin
                       next_state = DATA;
                    end
                 end
         DATA:   if (decide && bit_cnt == len_q - 4'd1) next_state = par_en_q ? PARITY : STOP;
         PARITY: if (decide) next_state = STOP;
         STOP:   if (decide && stop_cnt == stop2_q) begin
                    frame_done = 1'b1;
                    next_state = IDLE;
                 end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      case (par_typ_q)
         PAR_EVEN: exp_par = ^shreg;
         default:  exp_par = ~^shreg;
      endcase
   end

   // The final stop bit is still being decided when the frame closes.
   assign stp_err_final = stp_err_q | ~bit_val;
   assign busy          = (state != IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_meta     <= 1'b1;
         rx_s        <= 1'b1;
         rx_prev     <= 1'b1;
         par_en_q    <= 1'b0;
         par_typ_q   <= 1'b0;
         stop2_q     <= 1'b0;
         len_q       <= LEN_MAX;
         psc_q       <= PSC_MIN;
         shreg       <= '0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
         par_err_q   <= 1'b0;
         stp_err_q   <= 1'b0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         par_error   <= 1'b0;
         stp_error   <= 1'b0;
         strt_glitch <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         all_zero    <= 1'b0;
         brk_det     <= 1'b0;
`endif
      end else begin
         rx_meta     <= RX_IN;
         rx_s        <= rx_meta;
         rx_prev     <= rx_s;
         data_valid  <= 1'b0;
         par_error   <= 1'b0;
         stp_error   <= 1'b0;
         strt_glitch <= glitch;
`ifdef UART_RX_BREAK_DET_EN
         brk_det     <= 1'b0;
`endif
         if (start_det) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
            len_q     <= (DATA_LEN < LEN_MIN || DATA_LEN > LEN_MAX) ? LEN_MAX : DATA_LEN;
            psc_q     <= (Prescale < PSC_MIN) ? PSC_MIN : Prescale;
            shreg     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero  <= 1'b1;
`endif
         end
         if (decide) begin
            case (state)
               DATA: begin
                  shreg   <= shreg | (DATA_WIDTH_MAX'(bit_val) << bit_cnt);
                  bit_cnt <= bit_cnt + 4'd1;
               end
               PARITY: par_err_q <= (bit_val != exp_par);
               STOP: begin
                  stop_cnt  <= 1'b1;
                  stp_err_q <= stp_err_final;
               end
               default: ;
            endcase
`ifdef UART_RX_BREAK_DET_EN
            if (bit_val) all_zero <= 1'b0;
`endif
         end
         if (frame_done) begin
`ifdef UART_RX_BREAK_DET_EN
            if (all_zero && !bit_val) begin
               brk_det <= 1'b1;
            end else begin
               par_error <= par_err_q;
               stp_error <= stp_err_final;
            end
`else
            par_error <= par_err_q;
            stp_error <= stp_err_final;
`endif
            if (!par_err_q && !stp_err_final) begin
               data_valid <= 1'b1;
               P_DATA     <= shreg;
            end
         end
      end
   end

endmodule
